// File: rtl/uart_loopback_pkg.sv
// Shared types and constants for the UART loopback checker and its UART cores.
package uart_loopback_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_state_e;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;
    localparam int LOG_W      = 16;

endpackage

// File: rtl/uart_core.sv
// One 8N1 UART: independent transmitter and receiver sharing a bit-period parameter.
module uart_core
    import uart_loopback_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic       transmit,
    input  logic [7:0] tx_byte,
    output logic       received,
    output logic [7:0] rx_byte,
    output logic       is_receiving,
    output logic       is_transmitting,
    output logic       recv_error
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);

    bit_state_e       tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_idx;
    logic [7:0]       tx_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state        <= IDLE;
            tx_cnt          <= '0;
            tx_idx          <= '0;
            tx_shift        <= '0;
            tx              <= 1'b1;
            is_transmitting <= 1'b0;
        end else begin
            case (tx_state)
                IDLE: begin
                    if (transmit) begin
                        tx_shift        <= tx_byte;
                        tx              <= 1'b0;
                        tx_cnt          <= '0;
                        tx_state        <= START;
                        is_transmitting <= 1'b1;
                    end
                end
                START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx       <= tx_shift[0];
                        tx_state <= DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == DATA_LAST) begin
                            tx       <= 1'b1;
                            tx_state <= STOP;
                        end else begin
                            tx_idx   <= tx_idx + 1'b1;
                            tx       <= tx_shift[1];
                            tx_shift <= tx_shift >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt          <= '0;
                        tx_state        <= IDLE;
                        is_transmitting <= 1'b0;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    logic             rx_s1, rx_s2, rx_prev;
    bit_state_e       rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_idx;
    logic [7:0]       rx_shift;

    // Synchronizer flops reset high so a released reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_prev      <= 1'b1;
            rx_state     <= IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_shift     <= '0;
            rx_byte      <= '0;
            received     <= 1'b0;
            recv_error   <= 1'b0;
            is_receiving <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            received   <= 1'b0;
            recv_error <= 1'b0;
            case (rx_state)
                IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_cnt       <= '0;
                        rx_state     <= START;
                        is_receiving <= 1'b1;
                    end
                end
                START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        rx_idx <= '0;
                        if (rx_s2) begin
                            rx_state     <= IDLE;
                            is_receiving <= 1'b0;
                        end else begin
                            rx_state <= DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_idx == DATA_LAST) begin
                            rx_state <= STOP;
                        end else begin
                            rx_idx <= rx_idx + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt       <= '0;
                        rx_state     <= IDLE;
                        is_receiving <= 1'b0;
                        if (rx_s2) begin
                            rx_byte  <= rx_shift;
                            received <= 1'b1;
                        end else begin
                            recv_error <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_loopback_checker.sv
// Two UART cores with channel 1 looped into channel 2, logging {sent, received} pairs in a FIFO.
// Optional macro UARTV_MISMATCH_FLAG_EN adds a sticky mismatch flag and a recv_error2 pulse on mismatch.
module uart_loopback_checker
    import uart_loopback_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int LOG_DEPTH    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx1,
    output logic             tx1,
    input  logic             transmit1,
    input  logic [7:0]       tx_byte1,
    output logic             received1,
    output logic [7:0]       rx_byte1,
    output logic             is_receiving1,
    output logic             is_transmitting1,
    output logic             recv_error1,
    output logic             tx2,
    input  logic             transmit2,
    input  logic [7:0]       tx_byte2,
    output logic             received2,
    output logic [7:0]       rx_byte2,
    output logic             is_receiving2,
    output logic             is_transmitting2,
    output logic             recv_error2,
    input  logic             rd_en,
    input  logic             wr_clk,
    output logic [LOG_W-1:0] rd_data
);

    localparam int PTR_W = $clog2(LOG_DEPTH);

    logic frame_error2;

    uart_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ch1 (
        .clk(clk), .rst(rst), .rx(rx1), .tx(tx1),
        .transmit(transmit1), .tx_byte(tx_byte1),
        .received(received1), .rx_byte(rx_byte1),
        .is_receiving(is_receiving1), .is_transmitting(is_transmitting1),
        .recv_error(recv_error1)
    );

    uart_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ch2 (
        .clk(clk), .rst(rst), .rx(tx1), .tx(tx2),
        .transmit(transmit2), .tx_byte(tx_byte2),
        .received(received2), .rx_byte(rx_byte2),
        .is_receiving(is_receiving2), .is_transmitting(is_transmitting2),
        .recv_error(frame_error2)
    );

    // Mirrors the core's own latch condition: it loads tx_byte whenever idle with transmit high.
    logic [7:0] expected;

    always_ff @(posedge clk) begin
        if (rst) begin
            expected <= '0;
        end else if (transmit1 && !is_transmitting1) begin
            expected <= tx_byte1;
        end
    end

    logic [LOG_W-1:0] log_mem [LOG_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             ws1, ws2, ws_prev;
    logic             push, pop;

    assign push = received2 && (count != (PTR_W + 1)'(LOG_DEPTH));
    assign pop  = ws2 && !ws_prev && rd_en && (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            log_mem[wr_ptr] <= {expected, rx_byte2};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ws1     <= 1'b0;
            ws2     <= 1'b0;
            ws_prev <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            ws1     <= wr_clk;
            ws2     <= ws1;
            ws_prev <= ws2;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_data <= log_mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef UARTV_MISMATCH_FLAG_EN
    logic mismatch;
    logic mismatch_flag;

    assign mismatch = push && (expected != rx_byte2);

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_flag <= 1'b0;
        end else begin
            mismatch_flag <= mismatch_flag | mismatch;
        end
    end

    assign recv_error2 = frame_error2 | mismatch;
`else
    assign recv_error2 = frame_error2;
`endif

endmodule

// File: tb/tb_uart_loopback_checker.sv
// Randomized self-checking bench for uart_loopback_checker with a queue-based FIFO model.
module tb_uart_loopback_checker;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst, rx1, tx1, transmit1, received1, is_receiving1, is_transmitting1, recv_error1;
    logic [7:0]  tx_byte1, rx_byte1, tx_byte2, rx_byte2;
    logic        tx2, transmit2, received2, is_receiving2, is_transmitting2, recv_error2;
    logic        rd_en, wr_clk;
    logic [15:0] rd_data;

    always #5 clk = ~clk;

    uart_loopback_checker #(.CLKS_PER_BIT(CPB), .LOG_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx1(rx1), .tx1(tx1),
        .transmit1(transmit1), .tx_byte1(tx_byte1),
        .received1(received1), .rx_byte1(rx_byte1),
        .is_receiving1(is_receiving1), .is_transmitting1(is_transmitting1),
        .recv_error1(recv_error1),
        .tx2(tx2), .transmit2(transmit2), .tx_byte2(tx_byte2),
        .received2(received2), .rx_byte2(rx_byte2),
        .is_receiving2(is_receiving2), .is_transmitting2(is_transmitting2),
        .recv_error2(recv_error2),
        .rd_en(rd_en), .wr_clk(wr_clk), .rd_data(rd_data)
    );

    int checks = 0;
    int errors = 0;
    int rcv1_cnt = 0, err1_cnt = 0, rcv2_cnt = 0, err2_cnt = 0;

    logic [15:0] model_q [$];
    logic [15:0] model_rd = 16'h0000;
    logic [7:0]  seq_q [$];

    always @(negedge clk) begin
        if (received1)   rcv1_cnt++;
        if (recv_error1) err1_cnt++;
        if (received2)   rcv2_cnt++;
        if (recv_error2) err2_cnt++;
    end

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic sig_val(input int sel);
        return (sel == 0) ? is_transmitting1 : received2;
    endfunction

    task automatic wait_sig(input int sel, input logic level, input string tag);
        int n = 0;
        while (sig_val(sel) !== level && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 16'(sig_val(sel)), 16'(level));
    endtask

    // One frame of channel 1: bit-level waveform on tx1, then the looped-back byte on channel 2.
    task automatic send_frame(input logic [7:0] b);
        wait_sig(0, 1'b0, "wait_tx_idle");
        wait_sig(0, 1'b1, "wait_tx_start");
        repeat (CPB / 2) @(negedge clk);
        check_val("start_bit", 16'(tx1), 16'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            check_val($sformatf("data_bit%0d_of_%h", i, b), 16'(tx1), 16'(b[i]));
        end
        repeat (CPB) @(negedge clk);
        check_val("stop_bit", 16'(tx1), 16'd1);
        wait_sig(1, 1'b1, "wait_received2");
        check_val("rx_byte2", 16'(rx_byte2), 16'(b));
        if (model_q.size() < DEPTH) model_q.push_back({b, b});
    endtask

    task automatic run_frames();
        tx_byte1  = seq_q[0];
        transmit1 = 1'b1;
        for (int k = 0; k < seq_q.size(); k++) begin
            send_frame(seq_q[k]);
            if (k + 1 < seq_q.size()) tx_byte1 = seq_q[k + 1];
            else transmit1 = 1'b0;
        end
        repeat (2 * CPB) @(negedge clk);
        seq_q.delete();
    endtask

    task automatic strobe(input string tag);
        wr_clk = 1'b1;
        #50;
        wr_clk = 1'b0;
        #50;
        if (rd_en && model_q.size() > 0) model_rd = model_q.pop_front();
        @(negedge clk);
        check_val(tag, rd_data, model_rd);
    endtask

    task automatic drive_rx1(input logic [7:0] b, input logic stop_v);
        rx1 = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx1 = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx1 = stop_v;
        repeat (CPB) @(negedge clk);
        rx1 = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r1, e1, r2;
        rst = 1'b1; rx1 = 1'b1; transmit1 = 1'b0; tx_byte1 = 8'h00;
        transmit2 = 1'b0; tx_byte2 = 8'h00; rd_en = 1'b0; wr_clk = 1'b0;
        #30;
        @(negedge clk);
        check_val("reset_tx1", 16'(tx1), 16'd1);
        check_val("reset_tx2", 16'(tx2), 16'd1);
        check_val("reset_rd_data", rd_data, 16'h0000);
        check_val("reset_rx_byte2", 16'(rx_byte2), 16'h0000);
        check_val("reset_busy1", 16'(is_transmitting1), 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Eight frames: zero, three random, then the directed walking patterns.
        seq_q.push_back(8'h00);
        for (int i = 0; i < 3; i++) seq_q.push_back(8'($urandom_range(255)));
        seq_q.push_back(8'h80); seq_q.push_back(8'h0F);
        seq_q.push_back(8'hF0); seq_q.push_back(8'hFF);
        run_frames();
        check_val("recv_error2_count", 16'(err2_cnt), 16'd0);

        strobe("read_disabled");
        rd_en = 1'b1;
        for (int i = 0; i < 10; i++) strobe($sformatf("read_%0d", i));
        check_val("hold_after_empty", rd_data, 16'hFFFF);

        // Overflow: more frames than entries, no reads in between.
        rd_en = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) seq_q.push_back(8'($urandom_range(255)));
        run_frames();
        rd_en = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) strobe($sformatf("ovf_read_%0d", i));
        check_val("recv_error2_count_ovf", 16'(err2_cnt), 16'd0);

        // Channel 1 receiver: good frame, framing error, short glitch.
        r1 = rcv1_cnt; e1 = err1_cnt;
        drive_rx1(8'hA5, 1'b1);
        check_val("rx1_good_pulse", 16'(rcv1_cnt - r1), 16'd1);
        check_val("rx1_good_byte", 16'(rx_byte1), 16'h00A5);
        check_val("rx1_good_noerr", 16'(err1_cnt - e1), 16'd0);
        r1 = rcv1_cnt; e1 = err1_cnt;
        drive_rx1(8'h3C, 1'b0);
        check_val("rx1_ferr_pulse", 16'(err1_cnt - e1), 16'd1);
        check_val("rx1_ferr_norecv", 16'(rcv1_cnt - r1), 16'd0);
        check_val("rx1_ferr_byte_held", 16'(rx_byte1), 16'h00A5);
        r1 = rcv1_cnt; e1 = err1_cnt;
        rx1 = 1'b0;
        repeat (3) @(negedge clk);
        rx1 = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_val("glitch_norecv", 16'(rcv1_cnt - r1), 16'd0);
        check_val("glitch_noerr", 16'(err1_cnt - e1), 16'd0);
        check_val("glitch_idle", 16'(is_receiving1), 16'd0);

        // Reset in the middle of a frame, with one entry already logged.
        seq_q.push_back(8'h5A);
        run_frames();
        tx_byte1  = 8'h00;
        transmit1 = 1'b1;
        wait_sig(0, 1'b1, "wait_tx_start_rst");
        repeat (3 * CPB) @(negedge clk);
        r2  = rcv2_cnt;
        rst = 1'b1;
        @(negedge clk);
        check_val("midframe_tx1", 16'(tx1), 16'd1);
        check_val("midframe_busy1", 16'(is_transmitting1), 16'd0);
        transmit1 = 1'b0;
        rst = 1'b0;
        model_q.delete();
        model_rd = 16'h0000;
        repeat (2 * FRAME) @(negedge clk);
        check_val("midframe_no_received2", 16'(rcv2_cnt - r2), 16'd0);
        rd_en = 1'b1;
        strobe("midframe_fifo_empty");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
